// File: rtl/counter_pkg.sv
// Shared definitions for the count arbiter: FSM encoding, default counter
// width and the number of requesters.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int NUM_REQ       = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_core.sv
// Loadable WIDTH-bit wrap-around up/down counter. step_val exposes the value
// the counter would take on an enabled step, so the controller can detect term.
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] step_val
);

  logic [WIDTH-1:0] r_count;

  assign step_val = dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
  assign count    = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= step_val;
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that runs a shared up/down counter from a
// latched start value to a latched terminal value, then pulses done.
module count_arbiter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir,
  input  logic [WIDTH-1:0]   start0,
  input  logic [WIDTH-1:0]   start1,
  input  logic [WIDTH-1:0]   term0,
  input  logic [WIDTH-1:0]   term1,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic [NUM_REQ-1:0] done
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_idx;
  logic               r_last;
  logic               r_dir;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_term;
  logic [WIDTH-1:0]   w_step_val;
  logic               w_win;
  logic               w_held;
  logic               w_grant;
  logic               w_load;
  logic               w_en;
  logic               w_release;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  assign w_win   = (&req) ? ~r_last : req[1];
  assign w_held  = req[r_idx];
  assign w_grant = (r_state == S_IDLE) && (|req);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (!w_held) begin
          w_next_state = S_IDLE;
          w_release    = 1'b1;
        end else begin
          w_load       = 1'b1;
          w_next_state = (r_start == r_term) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_held) begin
          w_next_state = S_IDLE;
          w_release    = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_step_val == r_term) w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_release    = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // r_last resets to 1 so the first contested grant goes to requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= 1'b0;
      r_last  <= 1'b1;
      r_dir   <= 1'b0;
      r_start <= '0;
      r_term  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_idx   <= w_win;
        r_gnt   <= w_win ? 2'b10 : 2'b01;
        r_dir   <= dir[w_win];
        r_start <= w_win ? start1 : start0;
        r_term  <= w_win ? term1 : term0;
      end else if (w_release) begin
        r_gnt  <= '0;
        r_last <= r_idx;
      end
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (w_en),
    .dir     (r_dir),
    .load_val(r_start),
    .count   (count),
    .step_val(w_step_val)
  );

  assign gnt  = r_gnt;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE) ? r_gnt : '0;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed self-checking bench for count_arbiter: reset, round-robin, up and
// down jobs with wrap, abort, asynchronous reset mid-job and latch isolation.
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic [3:0] start0 = '0, start1 = '0, term0 = '0, term1 = '0;
  logic [1:0] gnt, done;
  logic       busy;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  count_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .dir(dir),
    .start0(start0), .start1(start1), .term0(term0), .term1(term1),
    .gnt(gnt), .busy(busy), .count(count), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (count !== 4'd0 || gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got count=%0d gnt=%b busy=%b done=%b required 0/00/0/00", count, gnt, busy, done);
    end
    #7 reset = 1'b1;
    tick();
    $display("reset released");
  endtask

  // Both requesters held from reset with start == term: grants 01,10,01.
  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    logic [3:0] exp_c [2];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_c[0] = 4'd5;  exp_c[1] = 4'd9;
    start0 = 4'd5; term0 = 4'd5; start1 = 4'd9; term1 = 4'd9;
    req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (gnt !== exp_g[j]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b required %b", j, gnt, exp_g[j]);
      end
      if (j == 2) break;
      tick();
      checks++;
      if (count !== exp_c[j] || done !== exp_g[j]) begin
        errors++;
        $display("FAIL rr_done%0d: got count=%0d done=%b required %0d/%b", j, count, done, exp_c[j], exp_g[j]);
      end
      tick();
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: got gnt=%b busy=%b required 00/0", j, gnt, busy);
      end
      $display("rr job %0d granted %b", j, exp_g[j]);
    end
    req = 2'b00;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_release: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_up();
    req = 2'b01; dir = 2'b01; start0 = 4'd3; term0 = 4'd6;
    tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL up_grant: got gnt=%b busy=%b required 01/1", gnt, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 4'(3 + i) || done !== ((i == 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL up_step%0d: got count=%0d done=%b required %0d/%b", i, count, done, 3 + i, (i == 3) ? 2'b01 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || count !== 4'd6) begin
      errors++;
      $display("FAIL up_end: got gnt=%b done=%b busy=%b count=%0d required 00/00/0/6", gnt, done, busy, count);
    end
    $display("up job r0 3->6 complete");
  endtask

  task automatic test_down();
    logic [3:0] exp_c [4];
    exp_c[0] = 4'd1; exp_c[1] = 4'd0; exp_c[2] = 4'd15; exp_c[3] = 4'd14;
    req = 2'b10; dir = 2'b00; start1 = 4'd1; term1 = 4'd14;
    tick();
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL down_grant: got %b required 10", gnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || done !== ((i == 3) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL down_step%0d: got count=%0d done=%b required %0d/%b", i, count, done, exp_c[i], (i == 3) ? 2'b10 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL down_end: got gnt=%b busy=%b required 00/0", gnt, busy);
    end
    $display("down job r1 1->14 complete");
  endtask

  // Requester 1 was served last; the aborted requester-0 job must still move the pointer.
  task automatic test_abort();
    int seen_done = 0;
    req = 2'b01; dir = 2'b01; start0 = 4'd2; term0 = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 2'b00) seen_done++;
    end
    req = 2'b00;
    tick();
    if (done !== 2'b00) seen_done++;
    checks++;
    if (busy !== 1'b0 || count !== 4'd4 || gnt !== 2'b00 || seen_done != 0) begin
      errors++;
      $display("FAIL abort_hold: got busy=%b count=%0d gnt=%b done_pulses=%0d required 0/4/00/0", busy, count, gnt, seen_done);
    end
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL abort_pointer: got %b required 10", gnt);
    end
    req = 2'b00;
    tick();
    tick();
    $display("abort job r0 at count 4");
  endtask

  task automatic test_reset_mid_run();
    req = 2'b01; dir = 2'b01; start0 = 4'd0; term0 = 4'd10;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL rst_pre: got count=%0d required 2", count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: got count=%0d gnt=%b busy=%b done=%b required 0/00/0/00", count, gnt, busy, done);
    end
    #1 reset = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01 || count !== 4'd0 || done !== 2'b00) begin
      errors++;
      $display("FAIL rst_resume: got gnt=%b count=%0d done=%b required 01/0/00", gnt, count, done);
    end
    req = 2'b00;
    tick();
    tick();
    $display("reset mid-run handled");
  endtask

  task automatic test_latch_ignore();
    req = 2'b01; dir = 2'b01; start0 = 4'd2; term0 = 4'd9;
    tick();
    tick();
    start0 = 4'd12; term0 = 4'd3; dir = 2'b00;
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL latch_load: got count=%0d required 2", count);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (count !== 4'(2 + i) || done !== ((i == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL latch_step%0d: got count=%0d done=%b required %0d/%b", i, count, done, 2 + i, (i == 7) ? 2'b01 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0 || count !== 4'd9) begin
      errors++;
      $display("FAIL latch_end: got busy=%b count=%0d required 0/9", busy, count);
    end
    $display("latched job r0 2->9 complete");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_up();
    test_down();
    test_abort();
    test_reset_mid_run();
    test_latch_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and value width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately, regardless of clk.
REQ-004 SHALL have port req  input  2  per-requester job request; bit i belongs to requester i.
REQ-005 SHALL have port dir  input  2  per-requester direction; 1 = up, 0 = down.
REQ-006 SHALL have ports start0/start1  input  WIDTH  per-requester start value.
REQ-007 SHALL have ports term0/term1  input  WIDTH  per-requester terminal value.
REQ-008 SHALL have port gnt  output  2  one-hot grant; 00 when idle.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port count  output  WIDTH  current value of the shared counter.
REQ-011 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-013 IDLE: SHALL, on an edge with any req bit high, grant one requester, latch its dir/start/term, and go to LOAD; gnt is high from that edge onward.
REQ-014 Arbitration SHALL be round-robin: with both req high, the requester not served last wins; the first grant after reset goes to requester 0.
REQ-015 LOAD: SHALL set count to latched start, then go to DONE if start equals term, else to RUN.
REQ-016 RUN: SHALL step count by +1 (up) or -1 (down) per cycle, modulo 2^WIDTH (up: all-ones -> 0; down: 0 -> all-ones), and go to DONE on the edge where count becomes term.
REQ-017 DONE: SHALL assert done[granted] for exactly that one cycle, update the last-served pointer, then return to IDLE; gnt SHALL clear on the same edge.
REQ-018 Steps in RUN SHALL equal (term-start) mod 2^WIDTH (up) or (start-term) mod 2^WIDTH (down); total latency from grant edge to done cycle = steps+2 edges.
REQ-019 dir/start/term changes after latching SHALL be ignored until the next grant.
REQ-020 If the granted requester drops req during LOAD or RUN, the job SHALL abort: go to IDLE on the next edge, no done pulse, count holds its value, and the pointer is updated as if the job had been served.
REQ-021 A requester that sees done and still holds req SHALL be re-arbitrated from IDLE; the earliest new grant is 1 cycle after DONE.
REQ-022 count SHALL hold its value in IDLE and DONE.
REQ-023 gnt and done SHALL never have more than one bit set.

Reset
REQ-024 While reset = 0: state = IDLE, count = 0, gnt = 00, done = 00, busy = 0, pointer favours requester 0.
REQ-025 Reset asserted mid-job SHALL abort with no done pulse; operation resumes from IDLE on the first edge after reset = 1.

Structure
REQ-026 Shared package counter_pkg SHALL hold the FSM state encoding, the WIDTH default, and the requester count (2).
REQ-027 Counter datapath SHALL be one sub-module, count_core: a loadable WIDTH-bit wrap-around up/down counter with load, enable, and dir inputs.

Verification
REQ-028 req0, dir up, start 3, term 6: gnt=01 at edge N, count 3/4/5/6 after N+1..N+4, done=01 in the next cycle, gnt=00 after N+5.
REQ-029 req1, dir down, start 1, term 14: count 1,0,15,14; done=10 after 3 RUN steps.
REQ-030 Both req held continuously from reset: grants alternate 01,10,01; start = term gives a DONE cycle directly after LOAD.
REQ-031 req0 dropped after 2 RUN steps: no done, count holds, busy=0 next cycle, next simultaneous request grants requester 1.
REQ-032 reset=0 pulse mid-RUN, between clock edges: count=0, gnt=00, busy=0 immediately, no done pulse.
REQ-033 start0 changed during RUN (up 2->9, start 2 changed to 12 mid-job): the job completes at term 9 after 7 steps, unaffected.
